// File: rtl/seq_det_ctrl_pkg.sv
// Shared types and defaults for the serial sequence-detection run controller.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DIV   = 4;
    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 16;

    // Bits needed to hold a pattern length in the range 0..pat_w.
    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Configuration handshake bundle: pattern, length, overlap mode and match limit.
interface seq_det_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16,
    parameter int LEN_W = $clog2(PAT_W + 1)
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_limit;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/seq_det_ctrl_tick_gen.sv
// Sample-tick generator: one-cycle enable pulse every DIV clocks while enabled.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] count;

    // Divider counter: wraps at DIV-1, held at zero whenever disabled.
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            count <= '0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && (count == CW'(DIV - 1));

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config handshake, start/stop/limit sequencing, serial pattern
// detection on sample ticks and a saturating match counter.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    seq_det_ctrl_if.slave    cfg,
    input  logic             start,
    input  logic             stop,
    output logic             sample_tick,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    state_t           state, state_nxt;
    logic             configured;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;
    logic [CNT_W-1:0] limit;
    logic [PAT_W-1:0] history, hist_nxt;
    logic [LEN_W-1:0] fill, fill_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             pat_eq;
    logic             cfg_fire, cfg_legal, cfg_accept;
    logic             cfg_err_q;
    logic             tick_ok, run_entry, shift_en, hit;

    assign busy          = (state == RUN);
    assign done          = (state == DONE);
    assign cfg.cfg_ready = (state != RUN);
    assign cfg.cfg_err   = cfg_err_q;

    assign cfg_fire   = cfg.cfg_valid && (state != RUN);
    assign cfg_legal  = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_W'(PAT_W));
    assign cfg_accept = cfg_fire && cfg_legal;

    // A stop in the same cycle as a tick discards that sample.
    assign tick_ok = busy && sample_tick && !stop;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .tick  (sample_tick)
    );

    // Candidate datapath values for a sample taken this cycle.
    always_comb begin
        hist_nxt  = {history[PAT_W-2:0], w};
        fill_nxt  = (fill == LEN_W'(PAT_W)) ? fill : fill + 1'b1;
        count_nxt = (match_count == '1) ? match_count : match_count + 1'b1;
        pat_eq    = 1'b1;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            if (i < 32'(len) && hist_nxt[i] != pattern[i]) begin
                pat_eq = 1'b0;
            end
        end
    end

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        run_entry = 1'b0;
        shift_en  = 1'b0;
        hit       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start && configured && !stop) begin
                    state_nxt = RUN;
                    run_entry = 1'b1;
                end else if (cfg_accept) begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (tick_ok) begin
                    shift_en = 1'b1;
                    hit      = (fill_nxt >= len) && pat_eq;
                    if (hit && limit != '0 && count_nxt == limit) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Configuration registers and illegal-length error pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            configured <= 1'b0;
            pattern    <= '0;
            len        <= '0;
            overlap    <= 1'b0;
            limit      <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= cfg_fire && !cfg_legal;
            if (cfg_accept) begin
                configured <= 1'b1;
                pattern    <= cfg.cfg_pattern;
                len        <= cfg.cfg_len;
                overlap    <= cfg.cfg_overlap;
                limit      <= cfg.cfg_limit;
            end
        end
    end

    // Sample history, fill level, registered match pulse and match counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            history     <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= hit;
            if (run_entry) begin
                history     <= '0;
                fill        <= '0;
                match_count <= '0;
            end else if (shift_en) begin
                history <= hist_nxt;
                fill    <= (hit && !overlap) ? '0 : fill_nxt;
                if (hit) begin
                    match_count <= count_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: scoreboard of expected match counts fed
// by a behavioural detector model, plus directed checks on control behaviour.
module tb_seq_det_ctrl;

    localparam int DIV   = 4;
    localparam int PAT_W = 8;
    localparam int CNT_W = 16;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic w = 1'b0;
    logic start = 1'b0;
    logic start_b = 1'b0;
    logic stop = 1'b0;

    logic             tick_a, busy_a, done_a, match_a;
    logic [CNT_W-1:0] mc_a;
    logic             tick_b, busy_b, done_b, match_b;
    logic [1:0]       mc_b;

    int n_checks = 0;
    int n_errors = 0;
    int nb_match = 0;

    int unsigned      sb_q[$];
    logic [PAT_W-1:0] m_pat, m_hist;
    int               m_len, m_fill, m_cnt;
    bit               m_ov;

    seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) cfg_a ();
    seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(2),     .LEN_W(LEN_W)) cfg_b ();

    seq_det_ctrl #(.DIV(DIV), .PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .w           (w),
        .cfg         (cfg_a),
        .start       (start),
        .stop        (stop),
        .sample_tick (tick_a),
        .busy        (busy_a),
        .done        (done_a),
        .match       (match_a),
        .match_count (mc_a)
    );

    seq_det_ctrl #(.DIV(DIV), .PAT_W(PAT_W), .CNT_W(2), .LEN_W(LEN_W)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .w           (w),
        .cfg         (cfg_b),
        .start       (start_b),
        .stop        (stop),
        .sample_tick (tick_b),
        .busy        (busy_b),
        .done        (done_b),
        .match       (match_b),
        .match_count (mc_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every match pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (match_a) begin
            if (sb_q.size() == 0) check("match_unexpected", match_a, 0);
            else                  check("match_count_sb", mc_a, sb_q.pop_front());
        end
        if (match_b) nb_match++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cfg_write(input logic [7:0] pat, input int len, input bit ov,
                             input int lim, input bit exp_err);
        @(negedge clk);
        cfg_a.cfg_valid   = 1'b1;
        cfg_a.cfg_pattern = pat;
        cfg_a.cfg_len     = LEN_W'(len);
        cfg_a.cfg_overlap = ov;
        cfg_a.cfg_limit   = CNT_W'(lim);
        @(posedge clk);
        #1;
        cfg_a.cfg_valid = 1'b0;
        check("cfg_err", cfg_a.cfg_err, 32'(exp_err));
        if (!exp_err) begin
            m_pat = pat;
            m_len = len;
            m_ov  = ov;
        end
        @(posedge clk);
        #1;
        check("cfg_err_clear", cfg_a.cfg_err, 0);
    endtask

    task automatic start_run(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1;
        else     start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_b = 1'b0;
        m_hist  = '0;
        m_fill  = 0;
        m_cnt   = 0;
    endtask

    task automatic stop_run();
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    // Sends n bits MSB-first, one per sample tick; models expected matches for DUT A.
    task automatic send_bits(input bit sel, input logic [15:0] bits, input int n,
                             output int first_wait);
        int  k;
        logic b, t;
        first_wait = 0;
        for (int i = n - 1; i >= 0; i--) begin
            b = bits[i];
            w = b;
            k = 0;
            do begin
                @(negedge clk);
                k++;
                t = sel ? tick_b : tick_a;
            end while (!t && k < 4 * DIV);
            if (!t) begin
                check("tick_timeout", t, 1);
                return;
            end
            if (i == n - 1) first_wait = k;
            if (!sel) begin
                m_hist = {m_hist[PAT_W-2:0], b};
                if (m_fill < PAT_W) m_fill++;
                if (m_fill >= m_len &&
                    ((int'(m_hist) ^ int'(m_pat)) & ((1 << m_len) - 1)) == 0) begin
                    if (m_cnt < 65535) m_cnt++;
                    sb_q.push_back(m_cnt);
                    if (!m_ov) m_fill = 0;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int fw, nt, k;
        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_pattern = '0; cfg_a.cfg_len = '0;
        cfg_a.cfg_overlap = 1'b0; cfg_a.cfg_limit = '0;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_pattern = '0; cfg_b.cfg_len = '0;
        cfg_b.cfg_overlap = 1'b0; cfg_b.cfg_limit = '0;
        m_pat = '0; m_hist = '0; m_len = 0; m_fill = 0; m_cnt = 0; m_ov = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_match", match_a, 0);
        check("rst_count", mc_a, 0);
        check("rst_tick", tick_a, 0);
        check("rst_cfg_ready", cfg_a.cfg_ready, 1);
        check("rst_cfg_err", cfg_a.cfg_err, 0);
        reset = 1'b1;

        // Start without configuration is ignored
        start_run(0);
        repeat (2) @(posedge clk);
        #1;
        check("busy_nocfg", busy_a, 0);

        // Basic non-overlap detection and first-tick latency
        cfg_write(8'b0000_0011, 4, 0, 0, 0);
        start_run(0);
        check("busy_run", busy_a, 1);
        check("cfg_ready_run", cfg_a.cfg_ready, 0);
        send_bits(0, 16'b0011, 4, fw);
        check("first_tick_delay", fw, DIV);
        check("match_pulse", match_a, 1);
        repeat (2) @(posedge clk);
        #1;
        check("basic_count", mc_a, 1);
        check("basic_drain", sb_q.size(), 0);
        stop_run();
        check("stop_idle", busy_a, 0);
        check("stop_count_held", mc_a, 1);

        // Reset mid-run
        start_run(0);
        send_bits(0, 16'b11, 2, fw);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mrst_busy", busy_a, 0);
        check("mrst_done", done_a, 0);
        check("mrst_match", match_a, 0);
        check("mrst_count", mc_a, 0);
        check("mrst_tick", tick_a, 0);
        check("mrst_cfg_ready", cfg_a.cfg_ready, 1);
        reset = 1'b1;
        start_run(0);
        repeat (2) @(posedge clk);
        #1;
        check("mrst_nocfg", busy_a, 0);

        // Overlapping versus non-overlapping
        cfg_write(8'b101, 3, 1, 0, 0);
        start_run(0);
        send_bits(0, 16'b10101, 5, fw);
        repeat (2) @(posedge clk);
        #1;
        check("ovl_count", mc_a, 2);
        check("ovl_drain", sb_q.size(), 0);
        stop_run();
        cfg_write(8'b101, 3, 0, 0, 0);
        start_run(0);
        send_bits(0, 16'b10101, 5, fw);
        repeat (2) @(posedge clk);
        #1;
        check("novl_count", mc_a, 1);
        check("novl_drain", sb_q.size(), 0);
        stop_run();

        // Illegal lengths, then a config attempt during RUN
        cfg_write(8'b11, 0, 1, 0, 1);
        cfg_write(8'b11, 9, 1, 0, 1);
        start_run(0);
        @(negedge clk);
        cfg_a.cfg_valid = 1'b1; cfg_a.cfg_pattern = 8'b11; cfg_a.cfg_len = LEN_W'(2);
        cfg_a.cfg_overlap = 1'b1; cfg_a.cfg_limit = '0;
        check("cfg_ready_busy", cfg_a.cfg_ready, 0);
        @(posedge clk);
        #1;
        cfg_a.cfg_valid = 1'b0;
        check("cfg_err_busy", cfg_a.cfg_err, 0);
        send_bits(0, 16'b101, 3, fw);
        repeat (2) @(posedge clk);
        #1;
        check("oldcfg_count", mc_a, 1);
        check("oldcfg_drain", sb_q.size(), 0);
        stop_run();

        // Match limit reaches DONE
        cfg_write(8'b11, 2, 0, 2, 0);
        start_run(0);
        send_bits(0, 16'b1111, 4, fw);
        check("lim_done", done_a, 1);
        check("lim_busy", busy_a, 0);
        check("lim_cfg_ready", cfg_a.cfg_ready, 1);
        nt = 0;
        repeat (12) begin
            @(negedge clk);
            if (tick_a) nt++;
        end
        check("lim_no_ticks", nt, 0);
        check("lim_done_hold", done_a, 1);
        check("lim_count", mc_a, 2);
        check("lim_drain", sb_q.size(), 0);
        cfg_write(8'b11, 2, 1, 0, 0);
        check("cfg_leaves_done", done_a, 0);
        check("cfg_leaves_done_busy", busy_a, 0);

        // start and stop together: stop wins
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", busy_a, 0);

        // stop on a tick cycle discards the sample
        start_run(0);
        send_bits(0, 16'b11, 2, fw);
        w = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick_a && k < 4 * DIV);
        check("stop_tick_seen", tick_a, 1);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("stop_tick_busy", busy_a, 0);
        check("stop_tick_match", match_a, 0);
        check("stop_tick_count", mc_a, 1);
        @(posedge clk);
        #1;
        check("stop_tick_match2", match_a, 0);
        check("stop_tick_drain", sb_q.size(), 0);

        // Saturation on a 2-bit counter
        @(negedge clk);
        cfg_b.cfg_valid = 1'b1; cfg_b.cfg_pattern = 8'b1; cfg_b.cfg_len = LEN_W'(1);
        cfg_b.cfg_overlap = 1'b0; cfg_b.cfg_limit = '0;
        @(posedge clk);
        #1;
        cfg_b.cfg_valid = 1'b0;
        start_run(1);
        nb_match = 0;
        send_bits(1, 16'b11111, 5, fw);
        repeat (2) @(posedge clk);
        #1;
        check("sat_pulses", nb_match, 5);
        check("sat_count", mc_b, 3);
        check("sat_busy", busy_b, 1);
        check("sat_done", done_b, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
